// File: rtl/usr_serial_sequencer.sv
// Serial TX/RX engine built around an external universal shift register.
// The block loads or clears the register, then shifts it one bit every DIV clocks.
module usr_serial_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rx,
    input  logic             cmd_msb_first,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       usr_ctrl,
    output logic [WIDTH-1:0] usr_d,
    input  logic [WIDTH-1:0] usr_q,
    output logic             ser_out,
    input  logic             ser_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             done,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_LEFT  = 2'b01;
    localparam logic [1:0] CTRL_RIGHT = 2'b10;
    localparam logic [1:0] CTRL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             rx_q, rx_d;
    logic             msb_q, msb_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic tick_term;
    logic bit_last;

    assign tick_term = (tick_cnt_q == TW'(DIV - 1));
    assign bit_last  = (bit_cnt_q == BW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            rx_q       <= 1'b0;
            msb_q      <= 1'b0;
            data_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            msb_q      <= msb_d;
            data_q     <= data_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        msb_d      = msb_q;
        data_d     = data_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        usr_ctrl   = CTRL_HOLD;
        usr_d      = '0;
        ser_out    = 1'b1;
        done       = 1'b0;
        cmd_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rx_d       = cmd_rx;
                    msb_d      = cmd_msb_first;
                    data_d     = cmd_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                // RX loads zero so the register starts clear before bits arrive
                usr_ctrl = CTRL_LOAD;
                usr_d    = rx_q ? '0 : data_q;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                if (!rx_q) ser_out = msb_q ? usr_q[WIDTH-1] : usr_q[0];
                if (tick_term) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + BW'(1);
                    usr_ctrl   = msb_q ? CTRL_LEFT : CTRL_RIGHT;
                    // Serial-in enters at the end the register shifts away from
                    if (rx_q) begin
                        if (msb_q) usr_d[0] = ser_in;
                        else       usr_d[WIDTH-1] = ser_in;
                    end
                    if (bit_last) state_d = S_DONE;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                if (rx_q) begin
                    rx_data_d  = usr_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_usr_serial_sequencer.sv
// Bench for usr_serial_sequencer: DIV=4 and DIV=1 instances, each driving a
// behavioural shift register; per-cycle expectations derived from the word/bit timeline.
module tb_usr_serial_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]        cmd_valid;
    logic              cmd_rx, cmd_msb_first, ser_in;
    logic [W-1:0]      cmd_data;
    logic [1:0]        cmd_ready, ser_out, rx_valid, done, busy;
    logic [1:0][1:0]   usr_ctrl;
    logic [1:0][W-1:0] usr_d, usr_q, rx_data;
    logic [W-1:0]      exp_rx [2];

    int n_chk  = 0;
    int n_pass = 0;

    usr_serial_sequencer #(.WIDTH(W), .DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_rx(cmd_rx), .cmd_msb_first(cmd_msb_first), .cmd_data(cmd_data),
        .usr_ctrl(usr_ctrl[0]), .usr_d(usr_d[0]), .usr_q(usr_q[0]),
        .ser_out(ser_out[0]), .ser_in(ser_in), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .done(done[0]), .busy(busy[0])
    );

    usr_serial_sequencer #(.WIDTH(W), .DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_rx(cmd_rx), .cmd_msb_first(cmd_msb_first), .cmd_data(cmd_data),
        .usr_ctrl(usr_ctrl[1]), .usr_d(usr_d[1]), .usr_q(usr_q[1]),
        .ser_out(ser_out[1]), .ser_in(ser_in), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .done(done[1]), .busy(busy[1])
    );

    // Universal shift register: 00 hold, 01 left (d[0] in), 10 right (d[W-1] in), 11 load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) usr_q <= '0;
        else begin
            for (int i = 0; i < 2; i++) begin
                case (usr_ctrl[i])
                    2'b01:   usr_q[i] <= {usr_q[i][W-2:0], usr_d[i][0]};
                    2'b10:   usr_q[i] <= {usr_d[i][W-1], usr_q[i][W-1:1]};
                    2'b11:   usr_q[i] <= usr_d[i];
                    default: usr_q[i] <= usr_q[i];
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic chk_quiet(input int sel, input string tag);
        chk({tag, "_busy"},  32'(busy[sel]),      0);
        chk({tag, "_ready"}, 32'(cmd_ready[sel]), 1);
        chk({tag, "_ser"},   32'(ser_out[sel]),   1);
        chk({tag, "_ctrl"},  32'(usr_ctrl[sel]),  0);
        chk({tag, "_done"},  32'(done[sel]),      0);
    endtask

    task automatic idle_cycles(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ser_in = 1'($urandom);
            #1;
            chk_quiet(sel, "idle");
            chk("idle_rxv", 32'(rx_valid[sel]), 0);
        end
    endtask

    // Starts at a negedge; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run_cmd(input int sel, input bit rx, input bit msb, input logic [W-1:0] data,
                           input logic [W-1:0] stream, input bit hold, input bit wiggle);
        int dv, last, b;
        bit term, sbit;
        logic [W-1:0] word;
        dv   = (sel == 0) ? 4 : 1;
        last = 2 + W * dv;
        // stream[W-1] is the first bit on the line
        if (msb) word = stream;
        else for (int i = 0; i < W; i++) word[i] = stream[W-1-i];

        cmd_rx = rx; cmd_msb_first = msb; cmd_data = data; cmd_valid[sel] = 1'b1;
        chk("accept_ready", 32'(cmd_ready[sel]), 1);
        @(posedge clk);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) cmd_valid[sel] = 1'b0;
                cmd_rx = 1'($urandom); cmd_msb_first = 1'($urandom); cmd_data = W'($urandom);
            end
            if (wiggle && c == 2 + W * dv / 2) cmd_data = ~data;
            b    = (c >= 2 && c < last) ? (c - 2) / dv : 0;
            sbit = stream[W-1-b];
            ser_in = rx ? sbit : 1'($urandom);
            #1;
            if (c == 1) begin
                chk("load_ctrl",  32'(usr_ctrl[sel]), 3);
                chk("load_d",     32'(usr_d[sel]), rx ? 0 : 32'(data));
                chk("load_ser",   32'(ser_out[sel]), 1);
                chk("load_busy",  32'(busy[sel]), 1);
                chk("load_ready", 32'(cmd_ready[sel]), 0);
                chk("load_rxv",   32'(rx_valid[sel]), 0);
            end else if (c < last) begin
                term = ((c - 2) % dv) == dv - 1;
                chk("sh_ser",   32'(ser_out[sel]), rx ? 1 : (msb ? 32'(data[W-1-b]) : 32'(data[b])));
                chk("sh_ctrl",  32'(usr_ctrl[sel]), term ? (msb ? 1 : 2) : 0);
                if (term) chk("sh_d", 32'(usr_d[sel]),
                              !rx ? 0 : (msb ? 32'(sbit) : 32'(sbit) << (W - 1)));
                chk("sh_ready", 32'(cmd_ready[sel]), 0);
                chk("sh_done",  32'(done[sel]), 0);
                chk("sh_rxv",   32'(rx_valid[sel]), 0);
            end else if (c == last) begin
                chk("dn_done",  32'(done[sel]), 1);
                chk("dn_ctrl",  32'(usr_ctrl[sel]), 0);
                chk("dn_ser",   32'(ser_out[sel]), 1);
                chk("dn_busy",  32'(busy[sel]), 1);
                chk("dn_q",     32'(usr_q[sel]), rx ? 32'(word) : 0);
                chk("dn_rxv",   32'(rx_valid[sel]), 0);
            end else begin
                if (rx) exp_rx[sel] = word;
                chk_quiet(sel, "end");
                chk("end_rxv",  32'(rx_valid[sel]), 32'(rx));
                chk("end_rxd",  32'(rx_data[sel]), 32'(exp_rx[sel]));
            end
        end
    endtask

    task automatic abort_tx(input int sel, input logic [W-1:0] data);
        int dv;
        dv = (sel == 0) ? 4 : 1;
        cmd_rx = 1'b0; cmd_msb_first = 1'b1; cmd_data = data; cmd_valid[sel] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[sel] = 1'b0;
        repeat (2 + 4 * dv) @(negedge clk);
        #1;
        chk("abort_bit4", 32'(ser_out[sel]), 32'(data[W-5]));
        reset = 1'b1;
        #1;
        exp_rx[0] = '0; exp_rx[1] = '0;
        for (int s = 0; s < 2; s++) begin
            chk_quiet(s, "rst");
            chk("rst_d",   32'(usr_d[s]), 0);
            chk("rst_rxv", 32'(rx_valid[s]), 0);
            chk("rst_rxd", 32'(rx_data[s]), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(sel, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        bit hold, prev_hold;
        reset = 1'b1; cmd_valid = '0; cmd_rx = 1'b0; cmd_msb_first = 1'b0;
        cmd_data = '0; ser_in = 1'b0;
        exp_rx[0] = '0; exp_rx[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk_quiet(s, "por");
            chk("por_d",   32'(usr_d[s]), 0);
            chk("por_rxd", 32'(rx_data[s]), 0);
            chk("por_rxv", 32'(rx_valid[s]), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(0, 2);

        // Directed scenarios
        run_cmd(1, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0);
        idle_cycles(1, 2);
        run_cmd(0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
        idle_cycles(0, 1);
        run_cmd(0, 1'b1, 1'b1, 8'h00, 8'b1100_1010, 1'b0, 1'b0);
        run_cmd(0, 1'b1, 1'b0, 8'h00, 8'b1100_1010, 1'b0, 1'b0);
        run_cmd(0, 1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1);
        run_cmd(0, 1'b0, 1'b0, 8'h96, 8'h00, 1'b0, 1'b0);
        abort_tx(0, 8'hB6);
        run_cmd(0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_cmd(1, 1'b1, 1'b0, 8'h00, 8'h6E, 1'b0, 1'b0);
        run_cmd(1, 1'b0, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0);
        run_cmd(0, 1'b1, 1'b1, 8'h00, 8'h2D, 1'b0, 1'b0);
        run_cmd(0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0);
        idle_cycles(0, 1);

        // Randomized commands; a held cmd_valid chains the next word on the same instance
        prev_hold = 1'b0;
        sel = 0;
        for (int i = 0; i < 30; i++) begin
            if (!prev_hold) begin
                sel = int'($urandom_range(0, 1));
                idle_cycles(sel, int'($urandom_range(0, 2)));
            end
            hold = (i < 29) && ($urandom_range(0, 2) == 0);
            run_cmd(sel, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                    hold, 1'($urandom));
            prev_hold = hold;
        end
        idle_cycles(0, 2);
        idle_cycles(1, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
